uxa_ps2_txlgc: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. LED set, reset) to the keyboard.

---
 rtl/uxa_ps2_txlgc.sv | 163 ++++++++++++++++
 tb/tb_uxa_ps2_txlgc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uxa_ps2_txlgc.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then shifts one
// command byte (odd parity, stop) out on device clock falls and checks the device ack.
module uxa_ps2_txlgc #(
  parameter int INHIBIT_CYCLES = 1250,
  parameter int TIMEOUT_CYCLES = 187500
) (
  input  logic       sys_clk_i,
  input  logic       sys_reset_i,
  input  logic [7:0] dat_i,
  input  logic       we_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  input  logic       ps2_c_i,
  input  logic       ps2_d_i,
  output logic       ps2_c_oe_o,
  output logic       ps2_d_oe_o
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_REQ, S_SHIFT, S_ACK, S_WAITIDLE
  } state_t;

  state_t        r_state, w_state_next;
  logic [1:0]    r_c_sync, r_d_sync;
  logic          r_c_prev;
  logic [9:0]    r_shift, w_shift_next;
  logic [3:0]    r_bit_cnt, w_bit_cnt_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_busy, w_busy_next;
  logic          r_done, w_done_next;
  logic          r_err, w_err_next;
  logic          r_c_oe, w_c_oe_next;
  logic          r_d_oe, w_d_oe_next;

  logic w_fall, w_in_xfer, w_timeout;

  assign w_fall    = r_c_prev & ~r_c_sync[1];
  assign w_in_xfer = (r_state == S_REQ) || (r_state == S_SHIFT) ||
                     (r_state == S_ACK) || (r_state == S_WAITIDLE);
  assign w_timeout = w_in_xfer && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Synchronizers idle high so a reset never fabricates a clock fall.
  always_ff @(posedge sys_clk_i or negedge sys_reset_i) begin
    if (!sys_reset_i) begin
      r_state   <= S_IDLE;
      r_c_sync  <= 2'b11;
      r_d_sync  <= 2'b11;
      r_c_prev  <= 1'b1;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_c_oe    <= 1'b0;
      r_d_oe    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_c_sync  <= {r_c_sync[0], ps2_c_i};
      r_d_sync  <= {r_d_sync[0], ps2_d_i};
      r_c_prev  <= r_c_sync[1];
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_cnt     <= w_cnt_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
      r_err     <= w_err_next;
      r_c_oe    <= w_c_oe_next;
      r_d_oe    <= w_d_oe_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_cnt_next     = r_cnt;
    w_busy_next    = r_busy;
    w_done_next    = 1'b0;
    w_err_next     = 1'b0;
    w_c_oe_next    = r_c_oe;
    w_d_oe_next    = r_d_oe;

    if (w_timeout) begin
      w_state_next = S_IDLE;
      w_c_oe_next  = 1'b0;
      w_d_oe_next  = 1'b0;
      w_busy_next  = 1'b0;
      w_err_next   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A start strobe coinciding with the done pulse is dropped.
          if (we_i && !r_done) begin
            w_shift_next = {1'b1, ~^dat_i, dat_i};
            w_busy_next  = 1'b1;
            w_c_oe_next  = 1'b1;
            w_d_oe_next  = 1'b0;
            w_cnt_next   = '0;
            w_state_next = S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
            w_d_oe_next  = 1'b1;
            w_cnt_next   = '0;
            w_state_next = S_START;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        S_START: begin
          w_c_oe_next    = 1'b0;
          w_d_oe_next    = 1'b1;
          w_cnt_next     = '0;
          w_bit_cnt_next = '0;
          w_state_next   = S_REQ;
        end
        S_REQ, S_SHIFT: begin
          w_cnt_next = r_cnt + 1'b1;
          if (w_fall) begin
            w_d_oe_next    = ~r_shift[r_bit_cnt];
            w_bit_cnt_next = r_bit_cnt + 1'b1;
            w_state_next   = (r_bit_cnt == 4'd9) ? S_ACK : S_SHIFT;
          end
        end
        S_ACK: begin
          w_cnt_next = r_cnt + 1'b1;
          if (w_fall) begin
            w_d_oe_next = 1'b0;
            if (!r_d_sync[1]) begin
              w_state_next = S_WAITIDLE;
            end else begin
              w_err_next   = 1'b1;
              w_busy_next  = 1'b0;
              w_state_next = S_IDLE;
            end
          end
        end
        S_WAITIDLE: begin
          w_cnt_next = r_cnt + 1'b1;
          if (r_c_sync[1] && r_d_sync[1]) begin
            w_done_next  = 1'b1;
            w_busy_next  = 1'b0;
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign ps2_c_oe_o = r_c_oe;
  assign ps2_d_oe_o = r_d_oe;

endmodule

// File: tb/tb_uxa_ps2_txlgc.sv
// Bench for uxa_ps2_txlgc: open-collector bus with a PS/2 device model and a
// transaction-level model of the expected busy/done/err/oe timeline.
module tb_uxa_ps2_txlgc;
  localparam int INH = 8;
  localparam int TMO = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] dat = 8'h00;
  logic       we = 1'b0;
  logic       busy, done, err, c_oe, d_oe;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic       ps2_c, ps2_d;

  assign ps2_c = dev_c & ~c_oe;
  assign ps2_d = dev_d & ~d_oe;

  uxa_ps2_txlgc #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .sys_clk_i  (clk),
    .sys_reset_i(rst_n),
    .dat_i      (dat),
    .we_i       (we),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .ps2_c_i    (ps2_c),
    .ps2_d_i    (ps2_d),
    .ps2_c_oe_o (c_oe),
    .ps2_d_oe_o (d_oe)
  );

  always #40 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // Transaction model: accept edge, edge of the done/err pulse, and its kind (1 = err).
  bit m_valid = 1'b0;
  int m_t0 = 0;
  int m_end = 0;
  bit m_kind = 1'b0;

  logic [4:0] c_act, c_exp, c_msk;
  int         c_r;
  logic [9:0] got;
  int         w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  // Output timeline: clock held 8 inhibit cycles plus START, start bit from START
  // until the device begins clocking, pulse on m_end, everything low otherwise.
  always @(negedge clk) begin
    c_act = {busy, done, err, c_oe, d_oe};
    c_exp = 5'b00000;
    c_msk = 5'b11111;
    if (rst_n && m_valid && cyc >= m_t0 && cyc <= m_end) begin
      c_r = cyc - m_t0;
      c_exp[4] = (cyc < m_end);
      c_exp[3] = (cyc == m_end) && !m_kind;
      c_exp[2] = (cyc == m_end) && m_kind;
      c_exp[1] = (c_r <= INH);
      if (cyc == m_end || c_r < INH) c_exp[0] = 1'b0;
      else if (c_r <= 15)            c_exp[0] = 1'b1;
      else                           c_msk[0] = 1'b0;
    end
    chk($sformatf("outputs@cyc%0d", cyc), 32'(c_act & c_msk), 32'(c_exp & c_msk));
  end

  task automatic tk(input int n);
    repeat (n) @(posedge clk);
    #5;
  endtask

  task automatic pulse_we(input logic [7:0] d, input bit arm);
    dat = d;
    we  = 1'b1;
    if (arm) begin
      m_valid = 1'b1;
      m_t0    = cyc + 1;
      m_end   = cyc + 1 + 1000000;
      m_kind  = 1'b0;
    end
    tk(1);
    we = 1'b0;
  endtask

  // Device: waits for request-to-send, clocks nfalls pulses sampling data at each rise,
  // then acks (data low across fall 11) or leaves data high.
  task automatic dev_xfer(input int nfalls, input bit ack, output logic [9:0] g);
    int wt = 0;
    g = '0;
    while (!(c_oe === 1'b0 && d_oe === 1'b1) && wt < 100) begin
      tk(1);
      wt++;
    end
    chk("request_seen", 32'(wt < 100), 32'd1);
    if (wt >= 100) return;
    tk(10);
    for (int k = 1; k <= nfalls && k <= 10; k++) begin
      dev_c = 1'b0;
      tk(10);
      g[k-1] = ps2_d;
      dev_c = 1'b1;
      tk(10);
    end
    if (nfalls == 11) begin
      if (ack) begin
        dev_d = 1'b0;
        tk(5);
        dev_c = 1'b0;
        tk(10);
        dev_c = 1'b1;
        tk(5);
        dev_d  = 1'b1;
        m_kind = 1'b0;
        m_end  = cyc + 3;
      end else begin
        dev_c  = 1'b0;
        m_kind = 1'b1;
        m_end  = cyc + 3;
        tk(10);
        dev_c = 1'b1;
      end
    end
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack, input logic [9:0] lit,
                          input bit we_at_done);
    logic [9:0] g;
    pulse_we(d, 1'b1);
    dev_xfer(11, ack, g);
    if (we_at_done) begin
      tk(3);
      pulse_we(8'h55, 1'b0);
    end
    chk("frame_model", 32'(g), 32'(frame_of(d)));
    chk("frame_literal", 32'(g), 32'(lit));
    tk(10);
    chk("idle_after_xfer", 32'({busy, c_oe, d_oe}), 32'd0);
    $display("xfer dat=%02h frame=%03h outcome=%s", d, g, ack ? "done" : "err");
  endtask

  initial begin
    // Reset with a start strobe inside it.
    tk(1);
    pulse_we(8'hED, 1'b0);
    tk(1);
    rst_n = 1'b1;
    tk(5);
    chk("idle_after_reset", 32'({busy, done, err, c_oe, d_oe}), 32'd0);
    $display("reset released, strobe during reset ignored");

    run_xfer(8'hED, 1'b1, 10'h3ED, 1'b1);

    // Second strobe mid-transfer must not disturb the frame.
    pulse_we(8'hF4, 1'b1);
    fork
      dev_xfer(11, 1'b1, got);
      begin
        tk(40);
        pulse_we(8'h00, 1'b0);
      end
    join
    chk("frame_model_f4", 32'(got), 32'(frame_of(8'hF4)));
    chk("frame_literal_f4", 32'(got), 32'h2F4);
    tk(10);
    $display("xfer dat=F4 frame=%03h outcome=done (strobe mid-transfer)", got);

    run_xfer(8'hA5, 1'b0, 10'h3A5, 1'b0);

    // Device never clocks: abort 400 cycles after entering the request phase.
    pulse_we(8'hFF, 1'b1);
    m_kind = 1'b1;
    m_end  = m_t0 + INH + 1 + TMO;
    w = 0;
    while (err !== 1'b1 && w < 600) begin
      tk(1);
      w++;
    end
    chk("timeout_latency", 32'(cyc - m_t0), 32'd409);
    tk(3);
    chk("released_after_timeout", 32'({busy, c_oe, d_oe}), 32'd0);
    $display("xfer dat=FF outcome=timeout after %0d cycles", cyc - 3 - m_t0);

    // Reset after fall 4 while the data line is being pulled low.
    pulse_we(8'hF4, 1'b1);
    dev_xfer(4, 1'b1, got);
    chk("bits_before_reset", 32'(got[3:0]), 32'h4);
    chk("d_oe_before_reset", 32'(d_oe), 32'd1);
    m_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("async_release", 32'({busy, done, err, c_oe, d_oe}), 32'd0);
    tk(2);
    rst_n = 1'b1;
    tk(3);
    $display("xfer dat=F4 aborted by reset after fall 4");

    run_xfer(8'hED, 1'b1, 10'h3ED, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #(80 * 50000);
    $display("FAIL watchdog: bench did not reach its end, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
